shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential shift-and-add multiplier core. Produces the WORD-wide product consumed by the
//  2:1 output-select mux stage directly downstream. Operands are captured on a start/ready
//  handshake, one multiplier bit is processed per clock, and a one-cycle done pulse marks a
//  stable product.
// PARAMETERS
//  WORD_LENGTH  4                 operand width, bits
//  WORD         WORD_LENGTH*2     product width, bits; never overridden independently
// PORTS
//  clk           in   1            single clock, rising edge
//  reset         in   1            asynchronous, active-high; forces reset values immediately
//  start         in   1            request; sampled only while ready=1
//  multiplicand  in   WORD_LENGTH  operand A; sampled on the accepted start cycle
//  multiplier    in   WORD_LENGTH  operand B; sampled on the accepted start cycle
//  ready         out  1            high only in IDLE; start is accepted when start & ready
//  done          out  1            one-cycle pulse; product is valid on this cycle
//  product       out  WORD         registered result; holds until the next DONE
// BEHAVIOUR
//  - Reset values: ready=1, done=0, product=0, state=IDLE, internal registers=0.
//  - FSM states and transitions:
//    IDLE -> LOAD on start. LOAD -> CALC unconditionally. CALC -> DONE when bit_count
//    reaches WORD_LENGTH-1. DONE -> IDLE unconditionally.
//  - LOAD: acc=0; mcand_r=zero-extended A (WORD bits); mplier_r=B; bit_count=0.
//  - CALC, once per cycle:
//    if mplier_r[0], acc=acc+mcand_r (WORD-bit add, carry discarded)
//    then mcand_r<<=1, mplier_r>>=1, bit_count++.
//  - DONE: product<=acc; done=1 for exactly this cycle; ready=0.
//  - Latency: start accepted at cycle N; done=1 at cycle N+WORD_LENGTH+2. Latency is fixed.
//    There is no early exit on zero operands.
//  - Overflow cannot occur: WORD = 2*WORD_LENGTH holds the full product.
//  - start while ready=0 is ignored; operands are not re-sampled.
//  - start held high continuously: a new operation is accepted on the first IDLE cycle after
//    DONE, so throughput is one result per WORD_LENGTH+3 cycles.
//  - Operand changes after acceptance have no effect on the result in flight.
//  - Reset mid-operation: the operation is aborted at once and outputs take reset values.
//    No done pulse is issued for the aborted operation.
//  - Reset deasserted in the same cycle as start: start is honoured only if sampled on a clk
//    edge with reset low.
// CONFIGURATION
//  Macro SIGNED_MULT_EN:
//  - Defined: operands are two's complement.
//    LOAD stores |A| and |B| and sign_r=A[MSB]^B[MSB].
//    DONE writes product = sign_r ? -acc : acc, as a WORD-bit two's complement value.
//    The most-negative operand (-2^(WORD_LENGTH-1)) is handled: its magnitude is treated as
//    unsigned.
//  - Undefined: operands and product are unsigned; no sign logic is synthesised.
//  Latency is identical in both builds.
// STRUCTURE
//  - Package multiplier_pkg: FSM state encoding (IDLE, LOAD, CALC, DONE, 2-bit localparams)
//    and the default WORD_LENGTH constant.
//  - Sub-module bit_counter: parameterised up-counter with synchronous clear and a terminal
//    flag at WORD_LENGTH-1. It is instantiated once.
//  - Top contains the FSM, acc/mcand_r/mplier_r registers and the adder.
// TESTING  (WORD_LENGTH=4)
//  1. Reset, then start with A=15, B=15 (unsigned build):
//     done at accept+6; product=8'hE1 (225); ready returns high the next cycle.
//  2. A=0, B=9: done still at accept+6; product=0. Then A=9, B=0: product=0.
//  3. SIGNED_MULT_EN: A=-3 (4'hD), B=5: product=8'hF1 (-15).
//     Then A=-8, B=-8: product=8'h40 (+64).
//  4. Start accepted with A=3, B=4; pulse start with A=7, B=7 during CALC:
//     product=8'h0C; exactly one done pulse.
//  5. Assert reset two cycles into CALC: ready=1, done=0, product=0 immediately.
//     No done pulse follows; the next operation completes correctly.
//  6. start held high with alternating operands: results arrive every 7 cycles, each
//     matching its own operands.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// multiplier_pkg: FSM state encoding and default operand width for shift_add_multiplier
package multiplier_pkg;
  localparam int WORD_LENGTH_DEF = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: start/ready request, operands, done pulse and product
interface shift_add_multiplier_if #(parameter int WORD_LENGTH = 4);
  localparam int WORD = WORD_LENGTH * 2;
  logic start;
  logic [WORD_LENGTH-1:0] multiplicand;
  logic [WORD_LENGTH-1:0] multiplier;
  logic ready;
  logic done;
  logic [WORD-1:0] product;
  modport master(output start, multiplicand, multiplier, input ready, done, product);
  modport slave(input start, multiplicand, multiplier, output ready, done, product);
endinterface

// File: rtl/shift_add_multiplier_bit_counter.sv
// bit_counter: up-counter with synchronous clear, flags the last of LIMIT steps
module bit_counter #(parameter int LIMIT = 4) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic last
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] count;
  // count processed multiplier bits; clear takes priority over counting
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= count + 1'b1;
  assign last = count == CW'(LIMIT - 1);
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier; define SIGNED_MULT_EN for two's complement operands
module shift_add_multiplier
  import multiplier_pkg::*;
#(parameter int WORD_LENGTH = WORD_LENGTH_DEF) (
  input logic clk,
  input logic reset,
  shift_add_multiplier_if.slave bus
);
  localparam int WORD = WORD_LENGTH * 2;
  state_t state, state_n;
  logic [WORD-1:0] acc, acc_n, mcand_r, result;
  logic [WORD_LENGTH-1:0] mplier_r, a_in, b_in;
  logic accept, last;
  assign accept = state == IDLE && bus.start;
  assign acc_n = acc + (mplier_r[0] ? mcand_r : '0);
`ifdef SIGNED_MULT_EN
  logic sign_r;
  // magnitudes are unsigned, so the most-negative operand maps to 2^(WORD_LENGTH-1)
  assign a_in = bus.multiplicand[WORD_LENGTH-1] ? -bus.multiplicand : bus.multiplicand;
  assign b_in = bus.multiplier[WORD_LENGTH-1] ? -bus.multiplier : bus.multiplier;
  assign result = sign_r ? -acc_n : acc_n;
  // remember the product sign from the accepted operands
  always_ff @(posedge clk or posedge reset)
    if (reset) sign_r <= 1'b0;
    else if (accept) sign_r <= bus.multiplicand[WORD_LENGTH-1] ^ bus.multiplier[WORD_LENGTH-1];
`else
  assign a_in = bus.multiplicand;
  assign b_in = bus.multiplier;
  assign result = acc_n;
`endif
  bit_counter #(.LIMIT(WORD_LENGTH)) u_count (
    .clk(clk),
    .reset(reset),
    .clear(state == LOAD),
    .en(state == CALC),
    .last(last)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state; ready and done decode straight from the state
  always_comb begin
    state_n = state;
    bus.ready = state == IDLE;
    bus.done = state == DONE;
    case (state)
      IDLE: state_n = bus.start ? LOAD : IDLE;
      LOAD: state_n = CALC;
      CALC: state_n = last ? DONE : CALC;
      default: state_n = IDLE;
    endcase
  end
  // operands are captured on accept so later input changes cannot disturb the operation;
  // product is written on the final add so it is already valid during the done cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      mcand_r <= '0;
      mplier_r <= '0;
      bus.product <= '0;
    end else if (accept) begin
      mcand_r <= WORD'(a_in);
      mplier_r <= b_in;
    end else if (state == LOAD) acc <= '0;
    else if (state == CALC) begin
      acc <= acc_n;
      mcand_r <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      if (last) bus.product <= result;
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: randomized self-checking bench against an arithmetic reference
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  shift_add_multiplier_if #(.WORD_LENGTH(4)) m();
  shift_add_multiplier #(.WORD_LENGTH(4)) dut (.clk(clk), .reset(reset), .bus(m.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
    int p;
`ifdef SIGNED_MULT_EN
    logic signed [3:0] sa, sb;
    sa = a;
    sb = b;
    p = int'(sa) * int'(sb);
`else
    p = int'(a) * int'(b);
`endif
    return p[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output logic [7:0] p, output int lat);
    lat = -1;
    p = 'x;
    m.start = 1'b1;
    m.multiplicand = a;
    m.multiplier = b;
    step();
    m.start = 1'b0;
    m.multiplicand = 4'($urandom);
    m.multiplier = 4'($urandom);
    for (int i = 1; i <= 20; i++) begin
      if (m.done === 1'b1) begin
        lat = i;
        p = m.product;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m.start = 1'b0;
    m.multiplicand = '0;
    m.multiplier = '0;
    repeat (2) step();
    checks++; if (m.ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", m.ready); else passed++;
    checks++; if (m.done !== 1'b0) $display("FAIL reset_done: got %b want 0", m.done); else passed++;
    checks++; if (m.product !== 8'h00) $display("FAIL reset_product: got %h want 00", m.product); else passed++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_max();
    logic [7:0] p;
    int lat;
    run_op(4'hF, 4'hF, p, lat);
    checks++; if (lat !== 6) $display("FAIL max_latency: got %0d want 6", lat); else passed++;
    checks++; if (p !== model(4'hF, 4'hF)) $display("FAIL max_product: got %h want %h", p, model(4'hF, 4'hF)); else passed++;
    step();
    checks++; if (m.ready !== 1'b1) $display("FAIL max_ready_after: got %b want 1", m.ready); else passed++;
    checks++; if (m.done !== 1'b0) $display("FAIL max_done_width: got %b want 0", m.done); else passed++;
  endtask

  task automatic test_zero();
    logic [7:0] p;
    int lat;
    run_op(4'h0, 4'h9, p, lat);
    step();
    checks++; if (lat !== 6) $display("FAIL zero_a_latency: got %0d want 6", lat); else passed++;
    checks++; if (p !== 8'h00) $display("FAIL zero_a_product: got %h want 00", p); else passed++;
    run_op(4'h9, 4'h0, p, lat);
    step();
    checks++; if (lat !== 6) $display("FAIL zero_b_latency: got %0d want 6", lat); else passed++;
    checks++; if (p !== 8'h00) $display("FAIL zero_b_product: got %h want 00", p); else passed++;
  endtask

  task automatic test_signed_corners();
    logic [7:0] p;
    int lat;
    run_op(4'hD, 4'h5, p, lat);
    step();
    checks++; if (p !== model(4'hD, 4'h5)) $display("FAIL neg3x5_product: got %h want %h", p, model(4'hD, 4'h5)); else passed++;
    run_op(4'h8, 4'h8, p, lat);
    step();
    checks++; if (p !== model(4'h8, 4'h8)) $display("FAIL neg8xneg8_product: got %h want %h", p, model(4'h8, 4'h8)); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] p;
    int lat;
    logic [3:0] a, b;
    for (int k = 0; k < 20; k++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      run_op(a, b, p, lat);
      step();
      checks++; if (lat !== 6) $display("FAIL rand_latency: %h*%h got %0d want 6", a, b, lat); else passed++;
      checks++; if (p !== model(a, b)) $display("FAIL rand_product: %h*%h got %h want %h", a, b, p, model(a, b)); else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [7:0] p = 'x;
    m.start = 1'b1;
    m.multiplicand = 4'h3;
    m.multiplier = 4'h4;
    step();
    m.start = 1'b0;
    step();
    m.start = 1'b1;
    m.multiplicand = 4'h7;
    m.multiplier = 4'h7;
    step();
    m.start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (m.done === 1'b1) begin
        pulses++;
        p = m.product;
      end
      step();
    end
    checks++; if (pulses !== 1) $display("FAIL ignore_pulses: got %0d want 1", pulses); else passed++;
    checks++; if (p !== model(4'h3, 4'h4)) $display("FAIL ignore_product: got %h want %h", p, model(4'h3, 4'h4)); else passed++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic [7:0] p;
    int lat;
    m.start = 1'b1;
    m.multiplicand = 4'h5;
    m.multiplier = 4'h6;
    step();
    m.start = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    checks++; if (m.ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", m.ready); else passed++;
    checks++; if (m.done !== 1'b0) $display("FAIL midreset_done: got %b want 0", m.done); else passed++;
    checks++; if (m.product !== 8'h00) $display("FAIL midreset_product: got %h want 00", m.product); else passed++;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m.done === 1'b1) pulses++;
      step();
    end
    checks++; if (pulses !== 0) $display("FAIL midreset_pulses: got %0d want 0", pulses); else passed++;
    run_op(4'hB, 4'h7, p, lat);
    step();
    checks++; if (lat !== 6) $display("FAIL midreset_next_latency: got %0d want 6", lat); else passed++;
    checks++; if (p !== model(4'hB, 4'h7)) $display("FAIL midreset_next_product: got %h want %h", p, model(4'hB, 4'h7)); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] a [6];
    logic [3:0] b [6];
    int prev = 0;
    bit seen;
    for (int k = 0; k < 6; k++) begin
      a[k] = (k % 2 == 0) ? 4'($urandom) : 4'hA;
      b[k] = (k % 2 == 0) ? 4'($urandom) : 4'h3;
    end
    m.start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      m.multiplicand = a[k];
      m.multiplier = b[k];
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (m.done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      checks++; if (!seen) $display("FAIL b2b_timeout: op %0d got no done want done", k); else passed++;
      checks++; if (m.product !== model(a[k], b[k])) $display("FAIL b2b_product: op %0d got %h want %h", k, m.product, model(a[k], b[k])); else passed++;
      if (k > 0) begin
        checks++; if (cyc - prev !== 7) $display("FAIL b2b_interval: op %0d got %0d want 7", k, cyc - prev); else passed++;
      end
      prev = cyc;
    end
    m.start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_max();
    test_zero();
    test_signed_corners();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
